// File: rtl/msu_sd_arbiter.sv
// Shares one SD sector-read port between the MSU audio streamer and the data-track
// reader: round-robin grant, request timeout, and short-sector detection.
module msu_sd_arbiter #(
   parameter int unsigned TIMEOUT      = 65535,
   parameter int unsigned SECTOR_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        aud_req,
   input  logic [31:0] aud_lba,
   input  logic        dat_req,
   input  logic [31:0] dat_lba,
   input  logic        sd_ack,
   input  logic        sd_buff_wr,
   output logic        sd_rd,
   output logic [31:0] sd_lba,
   output logic        aud_wr,
   output logic        dat_wr,
   output logic        aud_done,
   output logic        dat_done,
   output logic        xfer_err,
   output logic [8:0]  word_count,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   // Timeout fires on the last waiting cycle so sd_rd is high for exactly TIMEOUT cycles.
   localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);
   localparam logic [8:0]  SECTOR_CNT = 9'(SECTOR_WORDS);

   state_t      state;
   state_t      state_nxt;
   logic        grant_aud;
   logic        grant_aud_nxt;
   logic        last_aud;
   logic        last_aud_nxt;
   logic [15:0] wait_cnt;
   logic [15:0] wait_cnt_nxt;
   logic [8:0]  cnt;
   logic [8:0]  cnt_nxt;
   logic        sd_rd_nxt;
   logic [31:0] sd_lba_nxt;
   logic        aud_done_nxt;
   logic        dat_done_nxt;
   logic        xfer_err_nxt;
   logic [8:0]  word_count_nxt;
   logic        pick_aud;

   function automatic logic [8:0] sat_inc(input logic [8:0] v);
      return (v == 9'h1FF) ? v : v + 9'd1;
   endfunction

   // Audio wins when alone, or on a tie when data was served last.
   assign pick_aud = aud_req && (!dat_req || !last_aud);

   assign busy   = (state != IDLE);
   assign aud_wr = (state == XFER) &&  grant_aud && sd_buff_wr;
   assign dat_wr = (state == XFER) && !grant_aud && sd_buff_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant_aud  <= 1'b0;
         last_aud   <= 1'b0;
         wait_cnt   <= '0;
         cnt        <= '0;
         sd_rd      <= 1'b0;
         sd_lba     <= '0;
         aud_done   <= 1'b0;
         dat_done   <= 1'b0;
         xfer_err   <= 1'b0;
         word_count <= '0;
      end else begin
         state      <= state_nxt;
         grant_aud  <= grant_aud_nxt;
         last_aud   <= last_aud_nxt;
         wait_cnt   <= wait_cnt_nxt;
         cnt        <= cnt_nxt;
         sd_rd      <= sd_rd_nxt;
         sd_lba     <= sd_lba_nxt;
         aud_done   <= aud_done_nxt;
         dat_done   <= dat_done_nxt;
         xfer_err   <= xfer_err_nxt;
         word_count <= word_count_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_aud_nxt  = grant_aud;
      last_aud_nxt   = last_aud;
      wait_cnt_nxt   = wait_cnt;
      cnt_nxt        = cnt;
      sd_rd_nxt      = sd_rd;
      sd_lba_nxt     = sd_lba;
      aud_done_nxt   = 1'b0;
      dat_done_nxt   = 1'b0;
      xfer_err_nxt   = xfer_err;
      word_count_nxt = word_count;

      case (state)
         IDLE: begin
            if (aud_req || dat_req) begin
               grant_aud_nxt = pick_aud;
               sd_lba_nxt    = pick_aud ? aud_lba : dat_lba;
               sd_rd_nxt     = 1'b1;
               wait_cnt_nxt  = '0;
               state_nxt     = REQ;
            end
         end

         REQ: begin
            if (sd_ack) begin
               sd_rd_nxt = 1'b0;
               cnt_nxt   = '0;
               state_nxt = XFER;
            end else if (wait_cnt == WAIT_LAST) begin
               sd_rd_nxt      = 1'b0;
               xfer_err_nxt   = 1'b1;
               word_count_nxt = '0;
               aud_done_nxt   = grant_aud;
               dat_done_nxt   = !grant_aud;
               state_nxt      = DONE;
            end else begin
               wait_cnt_nxt = wait_cnt + 16'd1;
            end
         end

         XFER: begin
            if (!sd_ack) begin
               xfer_err_nxt   = (cnt != SECTOR_CNT);
               word_count_nxt = cnt;
               aud_done_nxt   = grant_aud;
               dat_done_nxt   = !grant_aud;
               state_nxt      = DONE;
            end else if (sd_buff_wr) begin
               cnt_nxt = sat_inc(cnt);
            end
         end

         DONE: begin
            last_aud_nxt = grant_aud;
            state_nxt    = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_msu_sd_arbiter.sv
// Randomized bench for msu_sd_arbiter: requesters and SD host are driven cycle by
// cycle while a transaction-level model predicts grants, routing and completion status.
module tb_msu_sd_arbiter;

   localparam int unsigned TIMEOUT      = 20;
   localparam int unsigned SECTOR_WORDS = 256;
   localparam int          NTXN         = 30;

   logic        clk = 1'b0;
   logic        reset;
   logic        aud_req;
   logic [31:0] aud_lba;
   logic        dat_req;
   logic [31:0] dat_lba;
   logic        sd_ack;
   logic        sd_buff_wr;
   logic        sd_rd;
   logic [31:0] sd_lba;
   logic        aud_wr;
   logic        dat_wr;
   logic        aud_done;
   logic        dat_done;
   logic        xfer_err;
   logic [8:0]  word_count;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: requester intent and round-robin memory.
   bit          aud_pend;
   bit          dat_pend;
   logic [31:0] aud_addr;
   logic [31:0] dat_addr;
   bit          last_aud;
   bit          win_aud;
   logic [31:0] exp_lba;
   logic [31:0] prev_wc;
   bit          prev_err;

   always #5 clk = ~clk;

   msu_sd_arbiter #(
      .TIMEOUT      (TIMEOUT),
      .SECTOR_WORDS (SECTOR_WORDS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .aud_req    (aud_req),
      .aud_lba    (aud_lba),
      .dat_req    (dat_req),
      .dat_lba    (dat_lba),
      .sd_ack     (sd_ack),
      .sd_buff_wr (sd_buff_wr),
      .sd_rd      (sd_rd),
      .sd_lba     (sd_lba),
      .aud_wr     (aud_wr),
      .dat_wr     (dat_wr),
      .aud_done   (aud_done),
      .dat_done   (dat_done),
      .xfer_err   (xfer_err),
      .word_count (word_count),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic perturb();
      if ($urandom_range(0, 7) == 0) begin
         aud_addr = $urandom;
         aud_lba  = aud_addr;
      end
      if ($urandom_range(0, 7) == 0) begin
         dat_addr = $urandom;
         dat_lba  = dat_addr;
      end
   endtask

   // One cycle of an active transfer (REQ or XFER phase).
   task automatic check_cycle(input string ph, input bit in_xfer, input bit rd);
      check({ph, "_sd_rd"},    32'(sd_rd),    32'(rd));
      check({ph, "_sd_lba"},   sd_lba,        exp_lba);
      check({ph, "_busy"},     32'(busy),     32'd1);
      check({ph, "_aud_wr"},   32'(aud_wr),   32'(in_xfer && win_aud && sd_buff_wr));
      check({ph, "_dat_wr"},   32'(dat_wr),   32'(in_xfer && !win_aud && sd_buff_wr));
      check({ph, "_aud_done"}, 32'(aud_done), 32'd0);
      check({ph, "_dat_done"}, 32'(dat_done), 32'd0);
   endtask

   task automatic do_abort(input bit rd_now);
      tick();
      reset      = 1'b1;
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      aud_pend   = 1'b0;
      dat_pend   = 1'b0;
      aud_req    = 1'b0;
      dat_req    = 1'b0;
      @(negedge clk);
      check("pre_rst_sd_rd", 32'(sd_rd), 32'(rd_now));
      tick();
      @(negedge clk);
      check("rst_sd_rd",      32'(sd_rd),      32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_aud_done",   32'(aud_done),   32'd0);
      check("rst_dat_done",   32'(dat_done),   32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_xfer_err",   32'(xfer_err),   32'd0);
      check("rst_sd_lba",     sd_lba,          32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_busy",     32'(busy),     32'd0);
      check("post_rst_aud_done", 32'(aud_done), 32'd0);
      check("post_rst_dat_done", 32'(dat_done), 32'd0);
      last_aud = 1'b0;
      prev_wc  = 32'd0;
      prev_err = 1'b0;
   endtask

   // kind: 0 normal transfer, 1 timeout, 2 reset while waiting, 3 reset mid-transfer
   task automatic run_txn(input int kind, input int nwords, input int ack_dly,
                          input int abort_at, input bit force_both);
      int          sent;
      logic [31:0] exp_wc;
      bit          exp_err;

      // Requester slot: the DUT is idle (or leaving DONE) at the next edge.
      tick();
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      if (!aud_pend && (force_both || $urandom_range(0, 1) == 1)) begin
         aud_pend = 1'b1;
         aud_addr = $urandom;
      end
      if (!dat_pend && (force_both || $urandom_range(0, 1) == 1)) begin
         dat_pend = 1'b1;
         dat_addr = $urandom;
      end
      if (!aud_pend && !dat_pend) begin
         if ($urandom_range(0, 1) == 1) begin
            aud_pend = 1'b1;
            aud_addr = $urandom;
         end else begin
            dat_pend = 1'b1;
            dat_addr = $urandom;
         end
      end
      aud_req = aud_pend;
      dat_req = dat_pend;
      aud_lba = aud_addr;
      dat_lba = dat_addr;
      if ($urandom_range(0, 3) == 0) begin
         sd_ack     = 1'b1;
         sd_buff_wr = 1'b1;
      end
      @(negedge clk);
      check("idle_busy",       32'(busy),       32'd0);
      check("idle_sd_rd",      32'(sd_rd),      32'd0);
      check("idle_aud_wr",     32'(aud_wr),     32'd0);
      check("idle_dat_wr",     32'(dat_wr),     32'd0);
      check("idle_aud_done",   32'(aud_done),   32'd0);
      check("idle_dat_done",   32'(dat_done),   32'd0);
      check("idle_word_count", 32'(word_count), prev_wc);
      check("idle_xfer_err",   32'(xfer_err),   32'(prev_err));

      win_aud = aud_pend && (!dat_pend || !last_aud);
      exp_lba = win_aud ? aud_addr : dat_addr;

      // Grant edge
      tick();
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
         if (win_aud) begin
            aud_pend = 1'b0;
            aud_req  = 1'b0;
         end else begin
            dat_pend = 1'b0;
            dat_req  = 1'b0;
         end
      end
      perturb();
      @(negedge clk);
      check_cycle("grant", 1'b0, 1'b1);
      check("grant_word_count", 32'(word_count), prev_wc);
      check("grant_xfer_err",   32'(xfer_err),   32'(prev_err));

      if (kind == 1) begin
         for (int k = 1; k < int'(TIMEOUT); k++) begin
            tick();
            perturb();
            @(negedge clk);
            check_cycle("wait", 1'b0, 1'b1);
         end
         exp_wc  = 32'd0;
         exp_err = 1'b1;
      end else if (kind == 2) begin
         for (int k = 0; k < ack_dly; k++) begin
            tick();
            perturb();
            @(negedge clk);
            check_cycle("wait", 1'b0, 1'b1);
         end
         do_abort(1'b1);
         return;
      end else begin
         for (int k = 0; k < ack_dly; k++) begin
            tick();
            perturb();
            @(negedge clk);
            check_cycle("wait", 1'b0, 1'b1);
         end
         tick();
         sd_ack     = 1'b1;
         sd_buff_wr = ($urandom_range(0, 1) == 1);
         perturb();
         @(negedge clk);
         check_cycle("ack", 1'b0, 1'b1);
         sent = 0;
         while (sent < nwords) begin
            tick();
            sd_buff_wr = ($urandom_range(0, 3) != 0);
            if (sd_buff_wr) sent++;
            perturb();
            @(negedge clk);
            check_cycle("xfer", 1'b1, 1'b0);
            if (kind == 3 && sent == abort_at) begin
               do_abort(1'b0);
               return;
            end
         end
         // Host drops ack; a stray strobe here is routed but never counted.
         tick();
         sd_ack     = 1'b0;
         sd_buff_wr = ($urandom_range(0, 1) == 1);
         perturb();
         @(negedge clk);
         check_cycle("ackdrop", 1'b1, 1'b0);
         exp_wc  = (sent > 511) ? 32'd511 : 32'(sent);
         exp_err = (exp_wc != 32'(SECTOR_WORDS));
      end

      // DONE cycle
      tick();
      sd_buff_wr = 1'b0;
      perturb();
      @(negedge clk);
      check("done_aud_done",   32'(aud_done),   32'(win_aud));
      check("done_dat_done",   32'(dat_done),   32'(!win_aud));
      check("done_xfer_err",   32'(xfer_err),   32'(exp_err));
      check("done_word_count", 32'(word_count), exp_wc);
      check("done_busy",       32'(busy),       32'd1);
      check("done_sd_rd",      32'(sd_rd),      32'd0);
      check("done_aud_wr",     32'(aud_wr),     32'd0);
      check("done_dat_wr",     32'(dat_wr),     32'd0);
      last_aud = win_aud;
      prev_wc  = exp_wc;
      prev_err = exp_err;
      if (win_aud) aud_pend = 1'b0;
      else         dat_pend = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      reset      = 1'b1;
      aud_req    = 1'b0;
      dat_req    = 1'b0;
      aud_lba    = '0;
      dat_lba    = '0;
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      aud_pend   = 1'b0;
      dat_pend   = 1'b0;
      aud_addr   = '0;
      dat_addr   = '0;
      last_aud   = 1'b0;
      win_aud    = 1'b0;
      exp_lba    = '0;
      prev_wc    = '0;
      prev_err   = 1'b0;

      repeat (3) tick();
      @(negedge clk);
      check("reset_sd_rd",      32'(sd_rd),      32'd0);
      check("reset_sd_lba",     sd_lba,          32'd0);
      check("reset_aud_wr",     32'(aud_wr),     32'd0);
      check("reset_dat_wr",     32'(dat_wr),     32'd0);
      check("reset_aud_done",   32'(aud_done),   32'd0);
      check("reset_dat_done",   32'(dat_done),   32'd0);
      check("reset_xfer_err",   32'(xfer_err),   32'd0);
      check("reset_word_count", 32'(word_count), 32'd0);
      check("reset_busy",       32'(busy),       32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("release_busy", 32'(busy), 32'd0);

      run_txn(0, 256, 3, 0, 1'b1);   // full sector, tie out of reset
      run_txn(1, 0,   0, 0, 1'b1);   // tie again, then timeout
      run_txn(0, 128, 2, 0, 1'b1);   // short sector
      run_txn(0, 520, 1, 0, 1'b0);   // count saturation
      run_txn(3, 256, 2, 100, 1'b0); // reset after 100 words
      for (int t = 5; t < NTXN; t++) begin
         r = $urandom_range(0, 19);
         if (r == 0)      run_txn(1, 0, 0, 0, 1'b0);
         else if (r == 1) run_txn(2, 0, $urandom_range(0, TIMEOUT - 3), 0, 1'b0);
         else if (r == 2) run_txn(3, 256, $urandom_range(0, 4), $urandom_range(1, 200), 1'b0);
         else if (r < 10) run_txn(0, 256, $urandom_range(0, 5), 0, 1'b0);
         else             run_txn(0, $urandom_range(0, 300), $urandom_range(0, 5), 0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
